display_receiver: RTL and testbench

DISPLAY_RECEIVER -- requirements
Module: display_receiver

---
 rtl/display_receiver_pkg.sv | 46 ++++
 rtl/display_receiver_if.sv | 27 ++
 rtl/display_spi_rx.sv | 44 ++++
 rtl/display_receiver.sv | 123 ++++++++++++
 tb/tb_display_receiver.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/display_receiver_pkg.sv
// Shared display command definitions: SSD1306 opcodes, parser states,
// and the argument-count lookup used by the command parser.
package display_receiver_pkg;

    // SSD1306 command opcodes
    localparam logic [7:0] OP_MEM_MODE     = 8'h20;
    localparam logic [7:0] OP_COL_ADDR     = 8'h21;
    localparam logic [7:0] OP_PAGE_ADDR    = 8'h22;
    localparam logic [7:0] OP_CONTRAST     = 8'h81;
    localparam logic [7:0] OP_CHARGE_PUMP  = 8'h8D;
    localparam logic [7:0] OP_DISPLAY_NORM = 8'hA6;
    localparam logic [7:0] OP_DISPLAY_INV  = 8'hA7;
    localparam logic [7:0] OP_MUX_RATIO    = 8'hA8;
    localparam logic [7:0] OP_DISPLAY_OFF  = 8'hAE;
    localparam logic [7:0] OP_DISPLAY_ON   = 8'hAF;
    localparam logic [7:0] OP_DISP_OFFSET  = 8'hD3;
    localparam logic [7:0] OP_CLK_DIV      = 8'hD5;
    localparam logic [7:0] OP_PRECHARGE    = 8'hD9;
    localparam logic [7:0] OP_COM_PINS     = 8'hDA;
    localparam logic [7:0] OP_VCOMH        = 8'hDB;

    // Reset value of the contrast register
    localparam logic [7:0] CONTRAST_DEFAULT = 8'h7F;

    // Command parser states
    typedef enum logic [1:0] {
        PS_CMD  = 2'd0,
        PS_ARG1 = 2'd1,
        PS_ARG2 = 2'd2
    } parser_state_t;

    // Number of argument bytes that follow an opcode
    function automatic logic [1:0] op_arg_count(input logic [7:0] op);
        logic [1:0] n;
        n = 2'd0;
        case (op)
            OP_COL_ADDR, OP_PAGE_ADDR:                 n = 2'd2;
            OP_CONTRAST, OP_MEM_MODE, OP_CLK_DIV,
            OP_MUX_RATIO, OP_DISP_OFFSET, OP_CHARGE_PUMP,
            OP_COM_PINS, OP_PRECHARGE, OP_VCOMH:        n = 2'd1;
            default:                                   n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/display_receiver_if.sv
// Serial bus from the host and framebuffer write port of the display receiver.
interface display_receiver_if;
    import display_receiver_pkg::*;

    logic       spi_clk;
    logic       spi_cs;
    logic       spi_din;
    logic       spi_dc;
    logic       spi_rst;
    logic       fb_we;
    logic [2:0] fb_page;
    logic [6:0] fb_column;
    logic [7:0] fb_data;

    // Host side: drives the serial bus, observes framebuffer writes
    modport master (
        output spi_clk, spi_cs, spi_din, spi_dc, spi_rst,
        input  fb_we, fb_page, fb_column, fb_data
    );

    // Receiver side
    modport slave (
        input  spi_clk, spi_cs, spi_din, spi_dc, spi_rst,
        output fb_we, fb_page, fb_column, fb_data
    );

endinterface

// File: rtl/display_spi_rx.sv
// Bit shifter: assembles MSB-first bytes from the serial bus sampled on clk,
// tags each byte with spi_dc and emits a one-cycle valid pulse.
module display_spi_rx
    import display_receiver_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_cs,
    input  logic       spi_din,
    input  logic       spi_dc,
    input  logic       spi_rst,
    output logic [7:0] rx_byte,
    output logic       rx_is_data,
    output logic       rx_vld
);

    logic [6:0] shift;
    logic [2:0] bit_cnt;

    // Shift register and bit counter; a deselect or display reset drops any partial byte
    always_ff @(posedge clk) begin
        if (reset || !spi_rst) begin
            shift      <= 7'd0;
            bit_cnt    <= 3'd0;
            rx_byte    <= 8'd0;
            rx_is_data <= 1'b0;
            rx_vld     <= 1'b0;
        end else begin
            rx_vld <= 1'b0;
            if (spi_cs) begin
                bit_cnt <= 3'd0;
            end else begin
                shift   <= {shift[5:0], spi_din};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_byte    <= {shift, spi_din};
                    rx_is_data <= spi_dc;
                    rx_vld     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/display_receiver.sv
// SSD1306-style display receiver: command parser, panel state registers and
// horizontal-addressing framebuffer write port fed by the serial shifter.
module display_receiver
    import display_receiver_pkg::*;
#(
    parameter int N_COLUMNS = 128,
    parameter int N_PAGES   = 8
) (
    input  logic                clk,
    input  logic                reset,
    display_receiver_if.slave   bus,
    output logic                display_on,
    output logic                inverted,
    output logic [7:0]          contrast
);

    localparam logic [6:0] COL_LAST  = 7'(N_COLUMNS - 1);
    localparam logic [2:0] PAGE_LAST = 3'(N_PAGES - 1);

    logic [7:0]    byte_p0;
    logic          is_data_p0;
    logic          vld_p0;

    parser_state_t pstate;
    logic [7:0]    cur_op;
    logic [6:0]    col;
    logic [6:0]    col_start;
    logic [6:0]    col_end;
    logic [2:0]    page;
    logic [2:0]    page_start;
    logic [2:0]    page_end;

    display_spi_rx u_rx (
        .clk        (clk),
        .reset      (reset),
        .spi_cs     (bus.spi_cs),
        .spi_din    (bus.spi_din),
        .spi_dc     (bus.spi_dc),
        .spi_rst    (bus.spi_rst),
        .rx_byte    (byte_p0),
        .rx_is_data (is_data_p0),
        .rx_vld     (vld_p0)
    );

    // Parser FSM, panel state, address window and framebuffer write strobe
    always_ff @(posedge clk) begin
        if (reset || !bus.spi_rst) begin
            pstate        <= PS_CMD;
            cur_op        <= 8'h00;
            display_on    <= 1'b0;
            inverted      <= 1'b0;
            contrast      <= CONTRAST_DEFAULT;
            col           <= 7'd0;
            col_start     <= 7'd0;
            col_end       <= COL_LAST;
            page          <= 3'd0;
            page_start    <= 3'd0;
            page_end      <= PAGE_LAST;
            bus.fb_we     <= 1'b0;
            bus.fb_page   <= 3'd0;
            bus.fb_column <= 7'd0;
            bus.fb_data   <= 8'd0;
        end else begin
            bus.fb_we <= 1'b0;
            if (vld_p0) begin
                case (pstate)
                    PS_CMD: begin
                        if (is_data_p0) begin
                            // Write at the current pointers, then advance horizontally
                            bus.fb_we     <= 1'b1;
                            bus.fb_page   <= page;
                            bus.fb_column <= col;
                            bus.fb_data   <= byte_p0;
                            if (col == col_end) begin
                                col  <= col_start;
                                page <= (page == page_end) ? page_start : page + 3'd1;
                            end else begin
                                col <= col + 7'd1;
                            end
                        end else begin
                            cur_op <= byte_p0;
                            case (byte_p0)
                                OP_DISPLAY_OFF:  display_on <= 1'b0;
                                OP_DISPLAY_ON:   display_on <= 1'b1;
                                OP_DISPLAY_NORM: inverted   <= 1'b0;
                                OP_DISPLAY_INV:  inverted   <= 1'b1;
                                default: ;
                            endcase
                            pstate <= (op_arg_count(byte_p0) != 2'd0) ? PS_ARG1 : PS_CMD;
                        end
                    end
                    PS_ARG1: begin
                        // Argument bytes are taken by position; spi_dc is ignored here
                        case (cur_op)
                            OP_COL_ADDR:  col_start  <= byte_p0[6:0];
                            OP_PAGE_ADDR: page_start <= byte_p0[2:0];
                            OP_CONTRAST:  contrast   <= byte_p0;
                            default: ;
                        endcase
                        pstate <= (op_arg_count(cur_op) == 2'd2) ? PS_ARG2 : PS_CMD;
                    end
                    PS_ARG2: begin
                        // Second argument closes the window and homes the pointer
                        case (cur_op)
                            OP_COL_ADDR: begin
                                col_end <= byte_p0[6:0];
                                col     <= col_start;
                            end
                            OP_PAGE_ADDR: begin
                                page_end <= byte_p0[2:0];
                                page     <= page_start;
                            end
                            default: ;
                        endcase
                        pstate <= PS_CMD;
                    end
                    default: pstate <= PS_CMD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_receiver.sv
// Scoreboard bench for display_receiver: expected framebuffer writes are queued
// by the stimulus, a negedge monitor pops and compares every fb_we pulse.
module tb_display_receiver;
    import display_receiver_pkg::*;

    logic       clk;
    logic       reset;
    logic       display_on;
    logic       inverted;
    logic [7:0] contrast;

    int vectors;
    int miscompares;

    // {page, column, data}
    logic [17:0] exp_q[$];

    display_receiver_if bus();

    display_receiver #(.N_COLUMNS(128), .N_PAGES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .display_on (display_on),
        .inverted   (inverted),
        .contrast   (contrast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    assign bus.spi_clk = clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_write(input logic [2:0] p, input logic [6:0] c, input logic [7:0] d);
        exp_q.push_back({p, c, d});
    endtask

    task automatic send_bit(input logic b, input logic dc);
        @(negedge clk);
        bus.spi_cs  = 1'b0;
        bus.spi_din = b;
        bus.spi_dc  = dc;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        for (int i = 7; i >= 0; i--) send_bit(b[i], dc);
    endtask

    task automatic release_cs();
        @(negedge clk);
        bus.spi_cs = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (bus.fb_we === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got p=%0d c=%0d d=%0h expected no write",
                         bus.fb_page, bus.fb_column, bus.fb_data);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if ({bus.fb_page, bus.fb_column, bus.fb_data} !== e) begin
                    miscompares++;
                    $display("FAIL write: got p=%0d c=%0d d=%0h expected p=%0d c=%0d d=%0h",
                             bus.fb_page, bus.fb_column, bus.fb_data, e[17:15], e[14:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.spi_rst = 1'b1;
        bus.spi_cs  = 1'b1;
        bus.spi_din = 1'b0;
        bus.spi_dc  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state with an idle bus
        wait_cycles(10);
        check("rst_display_on", 32'(display_on), 32'd0);
        check("rst_inverted",   32'(inverted),   32'd0);
        check("rst_contrast",   32'(contrast),   32'h7F);
        check("rst_fb_we",      32'(bus.fb_we),  32'd0);
        check("rst_fb_page",    32'(bus.fb_page), 32'd0);
        check("rst_fb_column",  32'(bus.fb_column), 32'd0);
        check("rst_fb_data",    32'(bus.fb_data), 32'd0);

        // Display on: visible exactly one cycle after the 8th bit
        send_byte(8'hAF, 1'b0);
        release_cs();
        check("on_before_update", 32'(display_on), 32'd0);
        @(posedge clk); #1;
        check("on_after_update",  32'(display_on), 32'd1);

        // Inverted
        send_byte(8'hA7, 1'b0);
        release_cs();
        check("inv_before_update", 32'(inverted), 32'd0);
        @(posedge clk); #1;
        check("inv_after_update",  32'(inverted), 32'd1);

        // One-arg opcode swallows its argument, even one that looks like display-off
        send_byte(8'hA8, 1'b0);
        send_byte(8'hAE, 1'b0);
        release_cs();
        wait_cycles(2);
        check("ignored_arg_display_on", 32'(display_on), 32'd1);
        check("ignored_arg_contrast",   32'(contrast),   32'h7F);

        // Contrast argument sent with dc=1: consumed as argument, no write
        send_byte(8'h81, 1'b0);
        send_byte(8'hAE, 1'b1);
        release_cs();
        wait_cycles(2);
        check("contrast_value",      32'(contrast),   32'hAE);
        check("contrast_display_on", 32'(display_on), 32'd1);

        // Partial byte aborted by chip select, then a full data byte
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
        release_cs();
        expect_write(3'd0, 7'd0, 8'h5A);
        send_byte(8'h5A, 1'b1);
        release_cs();
        wait_cycles(4);
        check("hold_fb_we",     32'(bus.fb_we),     32'd0);
        check("hold_fb_data",   32'(bus.fb_data),   32'h5A);
        check("hold_fb_column", 32'(bus.fb_column), 32'd0);
        check("hold_fb_page",   32'(bus.fb_page),   32'd0);

        // Window cols 16..18, pages 2..3 with back-to-back bytes, wrap back to (2,16)
        send_byte(8'h21, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        expect_write(3'd2, 7'd16, 8'h01);
        expect_write(3'd2, 7'd17, 8'h02);
        expect_write(3'd2, 7'd18, 8'h03);
        expect_write(3'd3, 7'd16, 8'h04);
        expect_write(3'd3, 7'd17, 8'h05);
        expect_write(3'd3, 7'd18, 8'h06);
        expect_write(3'd2, 7'd16, 8'h07);
        for (int d = 1; d <= 7; d++) send_byte(8'(d), 1'b1);
        release_cs();
        wait_cycles(4);
        check("window_writes_done", 32'(exp_q.size()), 32'd0);

        // Display reset mid-byte restores defaults
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
        @(negedge clk);
        bus.spi_rst = 1'b0;
        @(negedge clk);
        bus.spi_rst = 1'b1;
        bus.spi_cs  = 1'b1;
        #1;
        check("srst_display_on", 32'(display_on),    32'd0);
        check("srst_inverted",   32'(inverted),      32'd0);
        check("srst_contrast",   32'(contrast),      32'h7F);
        check("srst_fb_page",    32'(bus.fb_page),   32'd0);
        check("srst_fb_column",  32'(bus.fb_column), 32'd0);
        check("srst_fb_data",    32'(bus.fb_data),   32'd0);
        expect_write(3'd0, 7'd0, 8'h33);
        expect_write(3'd0, 7'd1, 8'h34);
        send_byte(8'h33, 1'b1);
        send_byte(8'h34, 1'b1);
        release_cs();
        wait_cycles(5);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
